// File: rtl/spi_slave_port.sv
// SPI mode-0 responder with oversampled pins and one-entry TX/RX holding registers.
// Optional macro SPI_SLAVE_OVERRUN_EN: keep the unread RX byte and set a sticky
// overrun flag instead of overwriting rx_data.
module spi_slave_port #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_ss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic       sclk_d, ss_d;
  logic       sclk_s, ss_s, mosi_s;
  logic       sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic [7:0] tx_shift, tx_hold, tx_src, rx_new;
  logic [6:0] rx_shift;
  logic [2:0] bit_cnt;
  logic       tx_full;
  logic       load_tx, shift_tx, shift_rx, clr_cnt, byte_done;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  assign tx_src    = tx_full ? tx_hold : IDLE_BYTE;
  assign rx_new    = {rx_shift, mosi_s};
  assign byte_done = shift_rx && (bit_cnt == 3'd7);

  assign busy        = (state == SHIFT);
  assign spi_miso_oe = (state == SHIFT);
  // miso follows the shifter MSB only while selected; it idles high otherwise
  assign spi_miso    = (state == SHIFT) ? tx_shift[7] : 1'b1;
  assign tx_ready    = ~tx_full;

  // Input synchronizers plus the delay registers used for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and per-cycle shifter strobes
  always_comb begin
    state_next = state;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    shift_rx   = 1'b0;
    clr_cnt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next = SHIFT;
          load_tx    = 1'b1;
          clr_cnt    = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_next = IDLE;
          clr_cnt    = 1'b1;
        end else if (sclk_rise) begin
          shift_rx = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt == 3'd0) load_tx  = 1'b1;
          else                 shift_tx = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift <= '1;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      if (load_tx)       tx_shift <= tx_src;
      else if (shift_tx) tx_shift <= {tx_shift[6:0], 1'b0};
      if (shift_rx)      rx_shift <= rx_new[6:0];
      if (clr_cnt)       bit_cnt  <= '0;
      else if (shift_rx) bit_cnt  <= bit_cnt + 3'd1;
    end
  end

  // TX holding register; write is only accepted when empty, load only drains when full
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_hold <= '0;
      tx_full <= 1'b0;
    end else if (tx_valid && !tx_full) begin
      tx_hold <= tx_data;
      tx_full <= 1'b1;
    end else if (load_tx && tx_full) begin
      tx_full <= 1'b0;
    end
  end

  // RX holding register and handshake
`ifdef SPI_SLAVE_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (byte_done) begin
      if (rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end else begin
        rx_data  <= rx_new;
        rx_valid <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (byte_done) begin
      rx_data  <= rx_new;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_port.sv
// Self-checking bench for spi_slave_port: table-driven single-byte transfers,
// a scoreboard queue for received bytes, and hand-written corner sequences.
module tb_spi_slave_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk, spi_ss, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       busy, overrun;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  rx_exp[$];

  spi_slave_port #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted RX byte is matched against the queue head
  always @(negedge clk) begin
    if (!reset && rx_valid && rx_ready) begin
      if (rx_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got %0h expected none", rx_data);
      end else begin
        check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp.pop_front()});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic ss_start();
    spi_ss = 1'b0;
    wait_clk(4);
  endtask

  task automatic ss_end();
    spi_ss = 1'b1;
    wait_clk(6);
  endtask

  // Mode 0: mosi set while sclk low, miso sampled just before the rising edge
  task automatic spi_xfer(input int nbits, input logic [7:0] mo, output logic [7:0] mi);
    mi = '0;
    for (int k = 0; k < nbits; k++) begin
      spi_mosi = mo[7-k];
      wait_clk(4);
      mi[7-k]  = spi_miso;
      spi_sclk = 1'b1;
      wait_clk(4);
      spi_sclk = 1'b0;
    end
  endtask

  typedef struct {
    logic       pre;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] mi;
    logic [7:0] exp_rx;
    logic       exp_ovr;

    vecs[0] = '{pre: 1'b1, tx: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5};
    vecs[1] = '{pre: 1'b0, tx: 8'h00, mosi: 8'hC3, exp_miso: 8'hFF};
    vecs[2] = '{pre: 1'b1, tx: 8'h00, mosi: 8'hFF, exp_miso: 8'h00};
    vecs[3] = '{pre: 1'b1, tx: 8'h5A, mosi: 8'h00, exp_miso: 8'h5A};
    vecs[4] = '{pre: 1'b1, tx: 8'h81, mosi: 8'h7E, exp_miso: 8'h81};

    reset = 1'b1; spi_sclk = 1'b0; spi_ss = 1'b1; spi_mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
    wait_clk(3);
    check("rst_miso", spi_miso, 1); check("rst_oe", spi_miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1); check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0); check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    wait_clk(2);

    // Table-driven single-byte transfers
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].pre) begin
        tx_write(vecs[i].tx);
        check("tx_ready_full", tx_ready, 0);
      end
      rx_exp.push_back(vecs[i].mosi);
      ss_start();
      check("busy_sel", busy, 1);
      check("oe_sel", spi_miso_oe, 1);
      check("tx_ready_after_start", tx_ready, 1);
      spi_xfer(8, vecs[i].mosi, mi);
      check("miso_byte", mi, vecs[i].exp_miso);
      ss_end();
      check("busy_idle", busy, 0);
    end

    // Empty-TX burst of two bytes
    rx_exp.push_back(8'h01); rx_exp.push_back(8'h02);
    ss_start();
    spi_xfer(8, 8'h01, mi); check("burst_miso0", mi, 8'hFF);
    spi_xfer(8, 8'h02, mi); check("burst_miso1", mi, 8'hFF);
    ss_end();

    // TX write during byte 0 lands on byte 1
    rx_exp.push_back(8'h10); rx_exp.push_back(8'h20);
    ss_start();
    tx_write(8'h11);
    spi_xfer(8, 8'h10, mi); check("late_tx_miso0", mi, 8'hFF);
    spi_xfer(8, 8'h20, mi); check("late_tx_miso1", mi, 8'h11);
    ss_end();

    // Abort after 5 bits, then a clean byte
    ss_start();
    spi_xfer(5, 8'hF0, mi);
    ss_end();
    check("abort_busy", busy, 0); check("abort_miso", spi_miso, 1);
    check("abort_oe", spi_miso_oe, 0); check("abort_rx_valid", rx_valid, 0);
    rx_exp.push_back(8'h7E);
    ss_start();
    spi_xfer(8, 8'h7E, mi); check("after_abort_miso", mi, 8'hFF);
    ss_end();

    // Unread RX byte followed by another byte
    rx_ready = 1'b0;
    ss_start(); spi_xfer(8, 8'hAA, mi); ss_end();
    ss_start(); spi_xfer(8, 8'h55, mi); ss_end();
`ifdef SPI_SLAVE_OVERRUN_EN
    exp_rx = 8'hAA; exp_ovr = 1'b1;
`else
    exp_rx = 8'h55; exp_ovr = 1'b0;
`endif
    check("ovr_rx_valid", rx_valid, 1);
    check("ovr_rx_data", rx_data, exp_rx);
    check("ovr_flag", overrun, exp_ovr);
    rx_exp.push_back(exp_rx);
    rx_ready = 1'b1;
    wait_clk(2);
    check("ovr_drained", rx_valid, 0);

    // Reset in the middle of a byte with a pending TX write
    ss_start();
    tx_write(8'h33);
    spi_xfer(3, 8'hC0, mi);
    check("pre_rst_tx_ready", tx_ready, 0);
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    wait_clk(1);
    check("mid_rst_miso", spi_miso, 1); check("mid_rst_oe", spi_miso_oe, 0);
    check("mid_rst_tx_ready", tx_ready, 1); check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_rx_data", rx_data, 0); check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun, 0);
    spi_ss = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(6);
    check("post_rst_busy", busy, 0);

    check("rx_queue_empty", rx_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
